psum_accumulator: RTL
=====================

Name: psum_accumulator

Overview:
- Accumulates signed partial sums from the PE array across cfg_num_tiles input-channel tiles per output pixel.
- Emits one saturated FEATURE_WIDTH sum per group.
- Sits directly upstream of the fixed-point scaler stage (multiply, then arithmetic shift right by 10); out_data feeds that stage's feature input.
- Valid/ready on both sides, with a separate output register so the next group accumulates while the result waits.

Parameters:
- FEATURE_WIDTH, 32: output width; must match the scaler's feature input.
- PSUM_WIDTH, 24: signed partial-sum input width.
- CNT_WIDTH, 8: tile counter width; max group length 2^CNT_WIDTH - 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of group and output state
- cfg_num_tiles  in  CNT_WIDTH  tiles per group; sampled on the first beat of each group
- in_valid  in  1  partial sum present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_psum  in  PSUM_WIDTH  signed partial sum
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_data  out  FEATURE_WIDTH  signed saturated group sum
- out_sat  out  1  out_data was clamped

Behaviour:
- Clock/reset: single clock clk. Reset is asynchronous, active-low, on rst_n.
- Reset values (rst_n=0): cnt=0, len=0, acc=0, out_valid=0, out_data=0, out_sat=0.
- Internal accumulator width: ACC_W = max(FEATURE_WIDTH, PSUM_WIDTH+CNT_WIDTH)+1. Internal accumulation never overflows.
- Beat = in_valid & in_ready.
- First beat (cnt==0):
  - len <= (cfg_num_tiles==0 ? 1 : cfg_num_tiles).
  - acc <= sign-extended in_psum; the previous acc is discarded.
  - cfg_num_tiles is ignored on all other beats.
- Middle beat: acc <= acc + sext(in_psum); cnt <= cnt+1.
- Last beat (cnt==len-1, or the first beat with len==1):
  - out_data <= clamp(acc_next) to [-2^(FEATURE_WIDTH-1), 2^(FEATURE_WIDTH-1)-1].
  - out_sat <= 1 iff clamped.
  - out_valid <= 1; cnt <= 0.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Output handshake:
  - out_valid & out_ready with no same-cycle last beat: out_valid <= 0; out_data holds its value.
  - Same-cycle last beat: out_valid stays 1 and out_data loads the new result. Gives full throughput at len=1.
  - out_data and out_sat are stable while out_valid & !out_ready.
- Backpressure: in_ready = !(out_valid & !out_ready & beat_would_be_last).
  - Non-last beats are always accepted.
  - in_ready depends combinationally on out_ready only; no in_valid → in_ready path.
- clear:
  - Takes priority over every other update: cnt<=0, acc<=0, out_valid<=0, out_sat<=0.
  - Any beat presented in the same cycle is dropped; in_ready is still driven by the normal equation.
- Reset mid-group discards the partial accumulation. The first beat after reset starts a new group.
- Saturation is at output only. Negative clamp: 0x8000_0000. Positive clamp: 0x7FFF_FFFF (FEATURE_WIDTH=32).
- No state machine beyond {cnt, out_valid}.
  - IDLE = cnt==0.
  - ACCUM = cnt!=0.
  - HOLD = out_valid & !out_ready. HOLD is orthogonal to IDLE/ACCUM.

Optional Feature:
- Macro: PSUM_ACCUMULATOR_BIAS_EN.
- Defined:
  - Adds port in_bias (in, FEATURE_WIDTH, signed).
  - First beat: acc <= sext(in_psum) + sext(in_bias).
  - in_bias is sampled only on first beats.
- Undefined: port absent; first beat loads in_psum only.
- Clamp rules are identical in both cases.

Decomposition:
- Shared package tnn_acc_pkg:
  - ACC_W computation function.
  - Signed clamp function sat_to_width.
  - Feature/psum width constants shared with the scaler stage.
- One sub-module: sat_clamp. Combinational ACC_W→FEATURE_WIDTH clamp with out_sat flag; reused by the post-scaler requantiser.
- Counter, handshake and registers stay in psum_accumulator.

Test Plan:
- Basic sum: cfg=4, psums 10,-3,100,7 back-to-back, out_ready=1 → one result, out_data=114, out_sat=0, one cycle after beat 4.
- Streaming with len zero-as-one: cfg=0, psums 5,6,7 continuous, out_ready=1 → out_data 5,6,7 on consecutive cycles; in_ready stays 1.
- Backpressure: cfg=2, out_ready=0 after the first result → out_data stable; the next group's beat 1 is accepted; in_ready=0 on beat 2 until out_ready=1; the second result then appears.
- Saturation: FEATURE_WIDTH=24, PSUM_WIDTH=24, cfg=2, psums 0x7FFFFF,0x000001 → out_data=0x7FFFFF, out_sat=1; psums 0x800000,0xFFFFFF → 0x800000, out_sat=1.
- Clear/reset mid-group: cfg=3, two beats, then clear (or rst_n pulse) → no output; next cfg=1, psum 9 → out_data=9.
- Bias (macro defined): in_bias=-20, cfg=2, psums 15,10 → out_data=5.

Source files
------------

// File: rtl/tnn_acc_pkg.sv
// -----------------------------------------------------------------------------
// tnn_acc_pkg
// Shared constants and helpers for the partial-sum accumulator and the
// fixed-point scaler / requantiser stages that consume its output.
//   FEATURE_WIDTH_DEF : feature width expected by the scaler's feature input
//   PSUM_WIDTH_DEF    : signed partial-sum width produced by the PE array
//   CNT_WIDTH_DEF     : tile counter width (max group length 2^CNT_WIDTH-1)
//   acc_width()       : internal accumulator width that can never overflow
//   sat_to_width()    : behavioural signed clamp of a 64-bit value to fw bits
// -----------------------------------------------------------------------------
package tnn_acc_pkg;

   localparam int FEATURE_WIDTH_DEF = 32;
   localparam int PSUM_WIDTH_DEF    = 24;
   localparam int CNT_WIDTH_DEF     = 8;

   // One extra bit beyond the larger of the output width and the worst-case
   // sum of (2^cw - 1) psums, so the clamp always sees the true sign.
   function automatic int acc_width(input int fw, input int pw, input int cw);
      return ((fw > (pw + cw)) ? fw : (pw + cw)) + 1;
   endfunction

   // Signed clamp into [-2^(fw-1), 2^(fw-1)-1]; valid for fw <= 63.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                       input int fw);
      logic signed [63:0] v_hi;
      logic signed [63:0] v_lo;
      v_hi = (64'sd1 <<< (fw - 1)) - 64'sd1;
      v_lo = -v_hi - 64'sd1;
      if (value > v_hi)
         return v_hi;
      else if (value < v_lo)
         return v_lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/sat_clamp.sv
// -----------------------------------------------------------------------------
// sat_clamp
// Combinational signed saturation from IN_W bits down to OUT_W bits.
// Requires IN_W > OUT_W.
//   i_value : signed wide input
//   o_value : clamped value, [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   o_sat   : high when i_value did not fit and was clamped
// -----------------------------------------------------------------------------
module sat_clamp #(
   parameter int IN_W  = 33,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  i_value,
   output logic [OUT_W-1:0] o_value,
   output logic             o_sat
);

   // The value fits iff every bit from the output sign bit upwards is a copy
   // of the input sign bit.
   logic [IN_W-OUT_W:0] w_top;
   logic                w_fits;

   assign w_top  = i_value[IN_W-1:OUT_W-1];
   assign w_fits = (&w_top) | ~(|w_top);

   always_comb begin
      o_sat   = ~w_fits;
      o_value = i_value[OUT_W-1:0];
      if (!w_fits) begin
         if (i_value[IN_W-1])
            o_value = {1'b1, {(OUT_W-1){1'b0}}};
         else
            o_value = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Sums signed partial sums over cfg_num_tiles input-channel tiles per output
// pixel and emits one saturated FEATURE_WIDTH result per group. A separate
// output register lets the next group accumulate while a result waits.
//
// Optional feature macro: PSUM_ACCUMULATOR_BIAS_EN
//   When defined, adds in_bias, which is added into the accumulator on the
//   first beat of each group.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   clear          : synchronous flush of group and output state
//   cfg_num_tiles  : tiles per group (0 treated as 1), sampled on first beat
//   in_valid/ready : partial-sum handshake, in_psum signed PSUM_WIDTH
//   in_bias        : (macro only) signed FEATURE_WIDTH bias, first beat only
//   out_valid/ready: result handshake
//   out_data       : signed saturated group sum
//   out_sat        : out_data was clamped
// -----------------------------------------------------------------------------
module psum_accumulator
   import tnn_acc_pkg::*;
#(
   parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
   parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [CNT_WIDTH-1:0]     cfg_num_tiles,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PSUM_WIDTH-1:0]    in_psum,
`ifdef PSUM_ACCUMULATOR_BIAS_EN
   input  logic [FEATURE_WIDTH-1:0] in_bias,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FEATURE_WIDTH-1:0] out_data,
   output logic                     out_sat
);

   localparam int ACC_W = acc_width(FEATURE_WIDTH, PSUM_WIDTH, CNT_WIDTH);

   logic [CNT_WIDTH-1:0]     r_cnt;
   logic [CNT_WIDTH-1:0]     r_len;
   logic [ACC_W-1:0]         r_acc;
   logic                     r_out_valid;
   logic [FEATURE_WIDTH-1:0] r_out_data;
   logic                     r_out_sat;

   logic                     w_first;
   logic [CNT_WIDTH-1:0]     w_len_first;
   logic [CNT_WIDTH-1:0]     w_len_eff;
   logic                     w_last;
   logic                     w_beat;
   logic [ACC_W-1:0]         w_psum_ext;
   logic [ACC_W-1:0]         w_first_base;
   logic [ACC_W-1:0]         w_acc_base;
   logic [ACC_W-1:0]         w_acc_next;
   logic [FEATURE_WIDTH-1:0] w_clamped;
   logic                     w_clamp_sat;

   assign w_first     = (r_cnt == '0);
   assign w_len_first = (cfg_num_tiles == '0) ? CNT_WIDTH'(1) : cfg_num_tiles;
   // On a first beat the group length is not yet registered, so use the
   // live configuration to decide whether this beat also closes the group.
   assign w_len_eff   = w_first ? w_len_first : r_len;
   assign w_last      = (r_cnt == (w_len_eff - CNT_WIDTH'(1)));

   // Only a group-closing beat can be blocked, and only by a held result.
   assign in_ready = ~(r_out_valid & ~out_ready & w_last);
   assign w_beat   = in_valid & in_ready;

   assign w_psum_ext = {{(ACC_W-PSUM_WIDTH){in_psum[PSUM_WIDTH-1]}}, in_psum};

`ifdef PSUM_ACCUMULATOR_BIAS_EN
   assign w_first_base = {{(ACC_W-FEATURE_WIDTH){in_bias[FEATURE_WIDTH-1]}}, in_bias};
`else
   assign w_first_base = '0;
`endif

   // A first beat discards whatever the previous group left in r_acc.
   assign w_acc_base = w_first ? w_first_base : r_acc;
   assign w_acc_next = w_acc_base + w_psum_ext;

   sat_clamp #(
      .IN_W  (ACC_W),
      .OUT_W (FEATURE_WIDTH)
   ) u_sat_clamp (
      .i_value (w_acc_next),
      .o_value (w_clamped),
      .o_sat   (w_clamp_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_len       <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else if (clear) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_sat   <= 1'b0;
      end else begin
         if (r_out_valid && out_ready)
            r_out_valid <= 1'b0;

         if (w_beat) begin
            if (w_first)
               r_len <= w_len_first;
            r_acc <= w_acc_next;
            if (w_last) begin
               // Overrides the consume above, so len=1 streams every cycle.
               r_cnt       <= '0;
               r_out_valid <= 1'b1;
               r_out_data  <= w_clamped;
               r_out_sat   <= w_clamp_sat;
            end else begin
               r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;

endmodule
